// File: rtl/alu_out_capture_pkg.sv
// Shared defaults and width helpers for the ALU result capture block.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
package alu_out_capture_pkg;

    localparam int DEF_RESULT_WIDTH = 16;
    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_TS_WIDTH     = 16;
    localparam int DEF_EDGE_MODE    = 0;

    localparam int               OVF_W   = 16;
    localparam logic [OVF_W-1:0] OVF_SAT = 16'hFFFF;

    // Channel index width; a single channel still needs one bit on the port.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/alu_out_capture_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module alu_out_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign do_pop   = pop && head_vld;
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/alu_out_capture.sv
// Captures per-channel ALU results with a timestamp into a shared FWFT queue.
// Latency: done at edge E0 -> FIFO write at E1 -> out_valid after E1.
// Backpressure: one pending slot per channel; events hitting a busy slot are dropped and counted.
module alu_out_capture
    import alu_out_capture_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int TS_WIDTH     = DEF_TS_WIDTH,
    parameter int EDGE_MODE    = DEF_EDGE_MODE,
    localparam int CH_W  = ch_width(NUM_CH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              done,
    input  logic [NUM_CH*RESULT_WIDTH-1:0] result,
    input  logic                           clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RESULT_WIDTH-1:0]        out_result,
    output logic [CH_W-1:0]                out_ch,
    output logic [TS_WIDTH-1:0]            out_ts,
    output logic [CNT_W-1:0]               count,
    output logic [OVF_W-1:0]               overflow_cnt
);

    localparam int ENT_W = CH_W + TS_WIDTH + RESULT_WIDTH;

    logic [TS_WIDTH-1:0]     ts_q;
    logic [NUM_CH-1:0]       done_q;
    logic [NUM_CH-1:0]       ev;
    logic [NUM_CH-1:0]       slot_vld;
    logic [RESULT_WIDTH-1:0] slot_res [NUM_CH];
    logic [TS_WIDTH-1:0]     slot_ts  [NUM_CH];
    logic [CH_W-1:0]         last_gnt;
    logic [OVF_W-1:0]        ovf_q;

    logic                    fifo_accept;
    logic                    gnt_vld;
    logic [CH_W-1:0]         gnt_idx;
    logic [CH_W-1:0]         cand;
    logic [NUM_CH-1:0]       gnt_sel;
    logic [NUM_CH-1:0]       drop;
    logic [3:0]              n_drop;
    logic [OVF_W:0]          ovf_sum;
    logic [OVF_W-1:0]        ovf_nxt;
    logic [ENT_W-1:0]        push_dat;
    logic [ENT_W-1:0]        head_dat;

    assign ev = (EDGE_MODE != 0) ? (done & ~done_q) : done;

    // A full FIFO can still take the grant when its head leaves this cycle.
    assign fifo_accept = (count != CNT_W'(DEPTH)) || (out_valid && out_ready);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (fifo_accept) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = CH_W'((int'(last_gnt) + k) % NUM_CH);
                if (!gnt_vld && slot_vld[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_sel = '0;
        if (gnt_vld) gnt_sel[gnt_idx] = 1'b1;
    end

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop[i] = ev[i] && slot_vld[i] && !gnt_sel[i];
            if (drop[i]) n_drop = n_drop + 4'd1;
        end
    end

    assign ovf_sum = {1'b0, ovf_q} + {{(OVF_W-3){1'b0}}, n_drop};
    assign ovf_nxt = ovf_sum[OVF_W] ? OVF_SAT : ovf_sum[OVF_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q     <= '0;
            done_q   <= '0;
            slot_vld <= '0;
            last_gnt <= CH_W'(NUM_CH - 1);
            ovf_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_res[i] <= '0;
                slot_ts[i]  <= '0;
            end
        end else begin
            done_q <= done;
            if (clear) begin
                ts_q     <= '0;
                slot_vld <= '0;
                last_gnt <= CH_W'(NUM_CH - 1);
                ovf_q    <= '0;
            end else begin
                ts_q  <= ts_q + TS_WIDTH'(1);
                ovf_q <= ovf_nxt;
                if (gnt_vld) last_gnt <= gnt_idx;
                // A slot drained this cycle can be refilled by a same-cycle event.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ev[i] && (!slot_vld[i] || gnt_sel[i])) begin
                        slot_vld[i] <= 1'b1;
                        slot_res[i] <= result[i*RESULT_WIDTH +: RESULT_WIDTH];
                        slot_ts[i]  <= ts_q;
                    end else if (gnt_sel[i]) begin
                        slot_vld[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign push_dat = {gnt_idx, slot_ts[gnt_idx], slot_res[gnt_idx]};

    alu_out_capture_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (clear),
        .push     (gnt_vld),
        .push_dat (push_dat),
        .pop      (out_ready),
        .head_vld (out_valid),
        .head_dat (head_dat),
        .count    (count)
    );

    assign out_result   = head_dat[RESULT_WIDTH-1:0];
    assign out_ts       = head_dat[RESULT_WIDTH +: TS_WIDTH];
    assign out_ch       = head_dat[RESULT_WIDTH+TS_WIDTH +: CH_W];
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_alu_out_capture.sv
// Bench for alu_out_capture: a level-mode and an edge-mode instance share stimulus,
// a queue-based reference model is compared every cycle, plus directed sequences.
module tb_alu_out_capture;

    localparam int RW  = 16;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              out_ready = 1'b0;
    logic [NCH-1:0]    done = '0;
    logic [NCH*RW-1:0] result = '0;

    logic        v0, v1;
    logic [15:0] r0_o, r1_o;
    logic [0:0]  ch0_o, ch1_o;
    logic [15:0] ts0_o;
    logic [3:0]  ts1_o;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;
    logic [15:0] ovf0, ovf1;

    int n_tests = 0;
    int n_fail  = 0;
    int pops0 = 0;
    int pops1 = 0;

    always #5 clk = ~clk;

    alu_out_capture #(.RESULT_WIDTH(16), .NUM_CH(2), .DEPTH(8), .TS_WIDTH(16), .EDGE_MODE(0)) u0 (
        .clk(clk), .rst(rst), .done(done), .result(result), .clear(clear),
        .out_valid(v0), .out_ready(out_ready), .out_result(r0_o), .out_ch(ch0_o),
        .out_ts(ts0_o), .count(cnt0), .overflow_cnt(ovf0));

    alu_out_capture #(.RESULT_WIDTH(16), .NUM_CH(2), .DEPTH(4), .TS_WIDTH(4), .EDGE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .done(done), .result(result), .clear(clear),
        .out_valid(v1), .out_ready(out_ready), .out_result(r1_o), .out_ch(ch1_o),
        .out_ts(ts1_o), .count(cnt1), .overflow_cnt(ovf1));

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (index 0 = level mode, 1 = edge mode) ----------------
    typedef struct { int res; int ch; int ts; } ent_t;
    ent_t mq [2][$];
    int m_sv [2][NCH];
    int m_sr [2][NCH];
    int m_st [2][NCH];
    int m_last [2];
    int m_ovf [2];
    int m_ts [2];
    int m_prev [NCH];
    int m_depth [2] = '{8, 4};
    int m_tsmod [2] = '{65536, 16};

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            m_last[m] = NCH - 1;
            m_ovf[m]  = 0;
            m_ts[m]   = 0;
            for (int i = 0; i < NCH; i++) m_sv[m][i] = 0;
        end
        for (int i = 0; i < NCH; i++) m_prev[i] = 0;
    endtask

    task automatic model_step(input int m);
        int ev [NCH];
        int drops;
        int g;
        int c;
        bit pop;
        for (int i = 0; i < NCH; i++) ev[i] = (done[i] && (m == 0 || m_prev[i] == 0)) ? 1 : 0;
        if (clear) begin
            mq[m].delete();
            for (int i = 0; i < NCH; i++) m_sv[m][i] = 0;
            m_ovf[m]  = 0;
            m_last[m] = NCH - 1;
            m_ts[m]   = 0;
            return;
        end
        pop = (mq[m].size() > 0) && out_ready;
        g = -1;
        if (mq[m].size() < m_depth[m] || pop) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last[m] + k) % NCH;
                if (g < 0 && m_sv[m][c] != 0) g = c;
            end
        end
        if (pop) void'(mq[m].pop_front());
        if (g >= 0) begin
            mq[m].push_back('{m_sr[m][g], g, m_st[m][g]});
            m_sv[m][g] = 0;
            m_last[m]  = g;
        end
        drops = 0;
        for (int i = 0; i < NCH; i++) begin
            if (ev[i] != 0) begin
                if (m_sv[m][i] != 0) drops++;
                else begin
                    m_sv[m][i] = 1;
                    m_sr[m][i] = int'(result[i*RW +: RW]);
                    m_st[m][i] = m_ts[m];
                end
            end
        end
        m_ovf[m] = (m_ovf[m] + drops > 65535) ? 65535 : m_ovf[m] + drops;
        m_ts[m]  = (m_ts[m] + 1) % m_tsmod[m];
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
            for (int i = 0; i < NCH; i++) m_prev[i] = done[i] ? 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (rst && v0 && out_ready) pops0++;
        if (rst && v1 && out_ready) pops1++;
    end

    task automatic chk_model(input int m, input int v, input int r, input int ch, input int ts,
                             input int cnt, input int ovf);
        int er, ech, ets;
        er = 0; ech = 0; ets = 0;
        if (mq[m].size() > 0) begin
            er = mq[m][0].res; ech = mq[m][0].ch; ets = mq[m][0].ts;
        end
        check($sformatf("m%0d_valid", m), v, (mq[m].size() > 0) ? 1 : 0);
        check($sformatf("m%0d_count", m), cnt, mq[m].size());
        check($sformatf("m%0d_result", m), r, er);
        check($sformatf("m%0d_ch", m), ch, ech);
        check($sformatf("m%0d_ts", m), ts, ets);
        check($sformatf("m%0d_ovf", m), ovf, m_ovf[m]);
    endtask

    always @(negedge clk) begin
        chk_model(0, int'(v0), int'(r0_o), int'(ch0_o), int'(ts0_o), int'(cnt0), int'(ovf0));
        chk_model(1, int'(v1), int'(r1_o), int'(ch1_o), int'(ts1_o), int'(cnt1), int'(ovf1));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  dn;
        logic [15:0] a;
        logic [15:0] b;
        logic        rdy;
        logic        ev;
        int          ec;
        logic [15:0] er;
        int          ech;
        int          ets;
    } vec_t;
    vec_t vt [19];

    initial begin
        int p0, p1;
        for (int i = 0; i < 5; i++) vt[i] = '{2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 0, 16'h0, 0, 0};
        vt[5]  = '{2'b01, 16'h1234, 16'h0,    1'b1, 1'b0, 0, 16'h0,    0, 0};
        vt[6]  = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h1234, 0, 5};
        vt[7]  = '{2'b11, 16'h0001, 16'h0002, 1'b1, 1'b0, 0, 16'h0,    0, 0};
        vt[8]  = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0002, 1, 7};
        vt[9]  = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0001, 0, 7};
        vt[10] = '{2'b11, 16'h0003, 16'h0004, 1'b1, 1'b0, 0, 16'h0,    0, 0};
        vt[11] = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0004, 1, 10};
        vt[12] = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0003, 0, 10};
        vt[13] = '{2'b10, 16'h0,    16'h0005, 1'b1, 1'b0, 0, 16'h0,    0, 0};
        vt[14] = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0005, 1, 13};
        vt[15] = '{2'b11, 16'h0006, 16'h0007, 1'b1, 1'b0, 0, 16'h0,    0, 0};
        vt[16] = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0006, 0, 15};
        vt[17] = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b1, 1, 16'h0007, 1, 15};
        vt[18] = '{2'b00, 16'h0,    16'h0,    1'b1, 1'b0, 0, 16'h0,    0, 0};

        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", v0, 0);
        check("rst_count", cnt0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_result", r0_o, 0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            done      = vt[i].dn;
            result    = {vt[i].b, vt[i].a};
            out_ready = vt[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), v0, vt[i].ev);
            check($sformatf("vec%0d_count", i), cnt0, vt[i].ec);
            check($sformatf("vec%0d_result", i), r0_o, vt[i].er);
            check($sformatf("vec%0d_ch", i), ch0_o, vt[i].ech);
            check($sformatf("vec%0d_ts", i), ts0_o, vt[i].ets);
        end

        // Held done with a stalled consumer: 8 buffered, 9th in slot, 3 dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            done   = 2'b01;
            result = {16'h0, 16'(16'h0100 + k)};
            step();
        end
        done = 2'b00;
        step();
        check("ovfl_count", cnt0, 8);
        check("ovfl_drops", ovf0, 3);
        check("ovfl_head", r0_o, 16'h0100);
        out_ready = 1'b1;
        step();
        check("full_pushpop_count", cnt0, 8);
        check("full_pushpop_head", r0_o, 16'h0101);
        check("full_pushpop_nodrop", ovf0, 3);
        for (int k = 0; k < 7; k++) step();
        check("slot_ninth", r0_o, 16'h0108);
        check("slot_ninth_count", cnt0, 1);
        step();
        check("drain_count", cnt0, 0);

        // Edge mode: held high -> one entry; low one cycle then high -> another.
        p0 = pops0;
        p1 = pops1;
        done   = 2'b10;
        result = {16'h0055, 16'h0};
        for (int k = 0; k < 5; k++) step();
        done = 2'b00;
        step();
        done   = 2'b10;
        result = {16'h0066, 16'h0};
        step();
        done = 2'b00;
        for (int k = 0; k < 4; k++) step();
        check("edge_entries", pops1 - p1, 2);
        check("level_entries", pops0 - p0, 6);
        check("level_ovf_kept", ovf0, 3);

        // Asynchronous reset with a partly filled FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            done   = 2'b01;
            result = {16'h0, 16'(16'h0200 + k)};
            step();
        end
        done = 2'b00;
        step();
        step();
        check("pre_rst_count", cnt0, 5);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", v0, 0);
        check("async_rst_count", cnt0, 0);
        check("async_rst_ovf", ovf0, 0);
        check("async_rst_result", r0_o, 0);
        check("async_rst_count_edge", cnt1, 0);
        @(negedge clk);
        rst    = 1'b1;
        done   = 2'b01;
        result = {16'h0, 16'h7777};
        step();
        done = 2'b00;
        step();
        check("first_after_rst_valid", v0, 1);
        check("first_after_rst_result", r0_o, 16'h7777);
        check("first_after_rst_ts", ts0_o, 0);

        // Synchronous clear with a full FIFO and drops outstanding.
        for (int k = 0; k < 12; k++) begin
            done   = 2'b01;
            result = {16'h0, 16'(16'h0300 + k)};
            step();
        end
        check("pre_clear_count", cnt0, 8);
        check("pre_clear_ovf", ovf0, 4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", cnt0, 0);
        check("clear_valid", v0, 0);
        check("clear_ovf", ovf0, 0);
        check("clear_count_edge", cnt1, 0);
        done   = 2'b01;
        result = {16'h0, 16'hABCD};
        step();
        done = 2'b00;
        step();
        check("post_clear_valid", v0, 1);
        check("post_clear_result", r0_o, 16'hABCD);
        check("post_clear_ts", ts0_o, 0);

        // Randomised traffic, compared cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            done      = NCH'($urandom_range(0, 3));
            result    = {16'($urandom), 16'($urandom)};
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 99) == 0);
            step();
        end
        clear = 1'b0;
        done  = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
